fsm_trace_sequencer: RTL and testbench

- Self-checking stimulus sequencer for the benchmark FSM blocks: 5 inputs x1..x5, 25 Mealy outputs y1..y25, active-high reset.
- Holds a programmable table of input vectors and expected output vectors. Resets the FSM under test (DUT), plays one vector per step, compares the DUT outputs against the expected vector, and reports pass/fail, the first failing step and the failing bits.
- Used in the trojan-detection harness to catch payloads such as output suppression after N visits to a state.

---
 rtl/fsm_trace_sequencer.sv | 144 ++++++++++++++
 tb/tb_fsm_trace_sequencer.sv | 312 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fsm_trace_sequencer.sv
// Table-driven stimulus sequencer for benchmark FSMs: resets the DUT, plays one input
// vector per two-cycle step and checks the Mealy outputs against stored expectations.
module fsm_trace_sequencer #(
    parameter int DEPTH        = 32,
    parameter int XW           = 5,
    parameter int YW           = 25,
    parameter int RST_CYC      = 2,
    parameter bit STOP_ON_FAIL = 1'b1
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       cfg_we,
    input  logic [$clog2(DEPTH)-1:0]   cfg_addr,
    input  logic [XW-1:0]              cfg_x,
    input  logic [YW-1:0]              cfg_y,
    input  logic [$clog2(DEPTH):0]     cfg_len,
    input  logic                       start,
    output logic                       busy,
    output logic                       done,
    output logic                       pass,
    output logic                       dut_rst,
    output logic [XW-1:0]              dut_x,
    output logic                       dut_adv,
    input  logic [YW-1:0]              dut_y,
    output logic [$clog2(DEPTH)-1:0]   fail_step,
    output logic [YW-1:0]              fail_mask,
    output logic [$clog2(DEPTH):0]     mismatch_cnt
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(RST_CYC) + 1;

    typedef enum logic [2:0] {IDLE, DRST, DRIVE, CHECK, DONE} state_t;

    state_t              state;
    logic [XW+YW-1:0]    tbl [DEPTH];
    logic [AW:0]         len;
    logic [AW-1:0]       k;
    logic [CW-1:0]       rst_cnt;

    logic [AW-1:0]       k_next;
    logic [XW-1:0]       x_first;
    logic [XW-1:0]       x_next;
    logic [YW-1:0]       y_exp;
    logic                mism;
    logic                last_step;
    logic [AW:0]         cnt_next;

    always_comb begin
        k_next    = k + 1'b1;
        x_first   = tbl[0][XW+YW-1:YW];
        x_next    = tbl[k_next][XW+YW-1:YW];
        y_exp     = tbl[k][YW-1:0];
        mism      = (dut_y != y_exp);
        cnt_next  = mismatch_cnt + (AW+1)'(mism);
        last_step = ({1'b0, k} == (len - 1'b1));
    end

    // The table is only writable while no run is reading it.
    always_ff @(posedge clk) begin
        if (cfg_we && (state == IDLE || state == DONE)) begin
            tbl[cfg_addr] <= {cfg_x, cfg_y};
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state        <= IDLE;
            busy         <= 1'b0;
            done         <= 1'b0;
            pass         <= 1'b0;
            dut_adv      <= 1'b0;
            dut_rst      <= 1'b1;
            dut_x        <= '0;
            fail_step    <= '0;
            fail_mask    <= '0;
            mismatch_cnt <= '0;
            len          <= '0;
            k            <= '0;
            rst_cnt      <= '0;
        end else begin
            dut_adv <= 1'b0;
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        len          <= cfg_len;
                        k            <= '0;
                        mismatch_cnt <= '0;
                        fail_step    <= '0;
                        fail_mask    <= '0;
                        rst_cnt      <= '0;
                        busy         <= 1'b1;
                        done         <= 1'b0;
                        pass         <= 1'b0;
                        dut_rst      <= 1'b1;
                        state        <= DRST;
                    end
                end
                DRST: begin
                    if (rst_cnt == CW'(RST_CYC - 1)) begin
                        dut_rst <= 1'b0;
                        if (len == '0) begin
                            busy  <= 1'b0;
                            done  <= 1'b1;
                            pass  <= 1'b1;
                            state <= DONE;
                        end else begin
                            dut_x <= x_first;
                            state <= DRIVE;
                        end
                    end else begin
                        rst_cnt <= rst_cnt + 1'b1;
                    end
                end
                DRIVE: begin
                    dut_adv <= 1'b1;
                    state   <= CHECK;
                end
                CHECK: begin
                    // Only the first mismatch of a run is recorded in detail.
                    if (mism) begin
                        mismatch_cnt <= cnt_next;
                        if (mismatch_cnt == '0) begin
                            fail_step <= k;
                            fail_mask <= dut_y ^ y_exp;
                        end
                    end
                    if (last_step || (mism && STOP_ON_FAIL)) begin
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        pass  <= (cnt_next == '0);
                        state <= DONE;
                    end else begin
                        k     <= k_next;
                        dut_x <= x_next;
                        state <= DRIVE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fsm_trace_sequencer.sv
// Bench for fsm_trace_sequencer: two instances (stop-on-fail and run-all) driving a
// behavioural FSM model with configurable output suppression.
module tb_fsm_trace_sequencer;

    localparam int DEPTH   = 32;
    localparam int RST_CYC = 2;
    localparam logic [24:0] ONES = 25'h004000E;

    typedef struct packed {
        int          cnt;
        int          step;
        logic [24:0] mask;
        logic        pass;
        int          adv;
        int          doneCyc;
    } res_t;

    typedef struct {
        int          len;
        logic [24:0] sm;
        int          lo;
        int          hi;
        res_t        e0;
        res_t        e1;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        cfgWe;
    logic [4:0]  cfgAddr;
    logic [4:0]  cfgX;
    logic [24:0] cfgY;
    logic [5:0]  cfgLen;
    logic        start;

    logic        busy [2];
    logic        done [2];
    logic        pass [2];
    logic        dutRst [2];
    logic        dutAdv [2];
    logic [4:0]  dutX [2];
    logic [24:0] dutY [2];
    logic [4:0]  failStep [2];
    logic [24:0] failMask [2];
    logic [5:0]  mismatchCnt [2];

    int          stepCnt [2];
    logic [24:0] supMask;
    int          supLo;
    int          supHi;

    logic [4:0]  tbX [DEPTH];
    logic [24:0] tbY [DEPTH];

    res_t        got [2];
    int          rstCyc [2];
    int          gapErr [2];
    int          timedOut;
    int          checks = 0;
    int          errors = 0;
    vec_t        vecs [7];

    always #5 clk = ~clk;

    fsm_trace_sequencer #(.DEPTH(DEPTH), .RST_CYC(RST_CYC), .STOP_ON_FAIL(1'b1)) dutStop (
        .clk(clk), .rst(rst), .cfg_we(cfgWe), .cfg_addr(cfgAddr), .cfg_x(cfgX), .cfg_y(cfgY),
        .cfg_len(cfgLen), .start(start), .busy(busy[0]), .done(done[0]), .pass(pass[0]),
        .dut_rst(dutRst[0]), .dut_x(dutX[0]), .dut_adv(dutAdv[0]), .dut_y(dutY[0]),
        .fail_step(failStep[0]), .fail_mask(failMask[0]), .mismatch_cnt(mismatchCnt[0]));

    fsm_trace_sequencer #(.DEPTH(DEPTH), .RST_CYC(RST_CYC), .STOP_ON_FAIL(1'b0)) dutAll (
        .clk(clk), .rst(rst), .cfg_we(cfgWe), .cfg_addr(cfgAddr), .cfg_x(cfgX), .cfg_y(cfgY),
        .cfg_len(cfgLen), .start(start), .busy(busy[1]), .done(done[1]), .pass(pass[1]),
        .dut_rst(dutRst[1]), .dut_x(dutX[1]), .dut_adv(dutAdv[1]), .dut_y(dutY[1]),
        .fail_step(failStep[1]), .fail_mask(failMask[1]), .mismatch_cnt(mismatchCnt[1]));

    // Model FSM output: a step-dependent function of x, with optional suppression window.
    function automatic logic [24:0] modelY(input logic [4:0] x, input int step,
                                           input logic [24:0] sm, input int lo, input int hi);
        logic [24:0] b;
        b = {x, x, x, x, x} ^ 25'(step * 32'h0000B5A3);
        b = b | ONES;
        if (step >= lo && step <= hi) b = b & ~sm;
        return b;
    endfunction

    always @(posedge clk) begin
        for (int j = 0; j < 2; j++) begin
            if (dutRst[j]) stepCnt[j] <= 0;
            else if (dutAdv[j]) stepCnt[j] <= stepCnt[j] + 1;
        end
    end

    always_comb begin
        dutY[0] = modelY(dutX[0], stepCnt[0], supMask, supLo, supHi);
        dutY[1] = modelY(dutX[1], stepCnt[1], supMask, supLo, supHi);
    end

    function automatic res_t mkRes(input int cnt, input int step, input logic [24:0] mask,
                                   input logic p, input int adv, input int dc);
        res_t r;
        r.cnt = cnt; r.step = step; r.mask = mask; r.pass = p; r.adv = adv; r.doneCyc = dc;
        return r;
    endfunction

    // Reference: walk the steps in order, each costing two cycles after the reset phase.
    function automatic res_t refRun(input int len, input bit stop, input logic [24:0] sm,
                                    input int lo, input int hi);
        res_t r;
        logic [24:0] act;
        r = '0;
        for (int i = 0; i < len; i++) begin
            act = modelY(tbX[i], i, sm, lo, hi);
            r.adv = r.adv + 1;
            if (act != tbY[i]) begin
                if (r.cnt == 0) begin
                    r.step = i;
                    r.mask = act ^ tbY[i];
                end
                r.cnt = r.cnt + 1;
                if (stop) break;
            end
        end
        r.pass = (r.cnt == 0);
        r.doneCyc = RST_CYC + 2 * r.adv + 1;
        return r;
    endfunction

    task automatic checkVal(input string name, input int j, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("[TB] FAIL %s[inst%0d] got %0h want %0h", name, j, act, exp);
        end
    endtask

    task automatic loadTable(input bit flips);
        for (int i = 0; i < DEPTH; i++) begin
            tbX[i] = 5'($urandom);
            tbY[i] = modelY(tbX[i], i, 25'h0, 1, 0);
            if (flips && $urandom_range(0, 3) == 0) tbY[i] = tbY[i] ^ (25'h1 << $urandom_range(0, 24));
            @(negedge clk);
            cfgWe = 1'b1; cfgAddr = 5'(i); cfgX = tbX[i]; cfgY = tbY[i];
        end
        @(negedge clk);
        cfgWe = 1'b0;
    endtask

    task automatic setSup(input logic [24:0] sm, input int lo, input int hi);
        supMask = sm; supLo = lo; supHi = hi;
    endtask

    // Starts a run and records what each instance does until it reports done.
    task automatic applyStimulus(input int len, input int wrCyc);
        int  cyc;
        bit  seen [2];
        int  lastAdv [2];
        for (int j = 0; j < 2; j++) begin
            got[j] = '0; rstCyc[j] = 0; gapErr[j] = 0; seen[j] = 1'b0; lastAdv[j] = -1;
        end
        timedOut = 0;
        @(negedge clk);
        cfgLen = 6'(len); start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        cyc = 1;
        forever begin
            if (cyc == wrCyc) begin
                cfgWe = 1'b1; cfgAddr = 5'd0; cfgX = ~tbX[0]; cfgY = ~tbY[0];
            end else begin
                cfgWe = 1'b0;
            end
            for (int j = 0; j < 2; j++) begin
                if (!seen[j]) begin
                    if (done[j]) begin
                        seen[j] = 1'b1;
                        got[j].doneCyc = cyc;
                        got[j].cnt = int'(mismatchCnt[j]);
                        got[j].step = int'(failStep[j]);
                        got[j].mask = failMask[j];
                        got[j].pass = pass[j];
                    end else begin
                        if (dutAdv[j]) begin
                            got[j].adv = got[j].adv + 1;
                            if (lastAdv[j] >= 0 && cyc - lastAdv[j] != 2) gapErr[j]++;
                            lastAdv[j] = cyc;
                        end
                        if (dutRst[j]) rstCyc[j]++;
                    end
                end
            end
            if (seen[0] && seen[1]) break;
            if (cyc >= 300) begin
                timedOut = 1;
                break;
            end
            cyc++;
            @(negedge clk);
        end
        cfgWe = 1'b0;
    endtask

    task automatic checkOutput(input string name, input res_t e0, input res_t e1);
        res_t e;
        for (int j = 0; j < 2; j++) begin
            e = (j == 0) ? e0 : e1;
            checkVal({name, ".timeout"}, j, timedOut, 0);
            checkVal({name, ".cnt"}, j, got[j].cnt, e.cnt);
            checkVal({name, ".failStep"}, j, got[j].step, e.step);
            checkVal({name, ".failMask"}, j, got[j].mask, e.mask);
            checkVal({name, ".pass"}, j, got[j].pass, e.pass);
            checkVal({name, ".advPulses"}, j, got[j].adv, e.adv);
            checkVal({name, ".doneCycle"}, j, got[j].doneCyc, e.doneCyc);
            checkVal({name, ".dutRstCycles"}, j, rstCyc[j], RST_CYC);
            checkVal({name, ".advSpacing"}, j, gapErr[j], 0);
        end
    endtask

    initial begin
        int n;
        int len;
        int lo;
        logic [24:0] sm;

        vecs[0] = '{len: 0,  sm: 25'h0,       lo: 0,  hi: 0,
                    e0: mkRes(0, 0, 25'h0, 1'b1, 0, 3),   e1: mkRes(0, 0, 25'h0, 1'b1, 0, 3)};
        vecs[1] = '{len: 3,  sm: 25'h0,       lo: 0,  hi: 0,
                    e0: mkRes(0, 0, 25'h0, 1'b1, 3, 9),   e1: mkRes(0, 0, 25'h0, 1'b1, 3, 9)};
        vecs[2] = '{len: 4,  sm: 25'h8,       lo: 1,  hi: 31,
                    e0: mkRes(1, 1, 25'h8, 1'b0, 2, 7),   e1: mkRes(3, 1, 25'h8, 1'b0, 4, 11)};
        vecs[3] = '{len: 8,  sm: 25'h4000E,   lo: 5,  hi: 7,
                    e0: mkRes(1, 5, 25'h4000E, 1'b0, 6, 15), e1: mkRes(3, 5, 25'h4000E, 1'b0, 8, 19)};
        vecs[4] = '{len: 32, sm: 25'h0,       lo: 0,  hi: 0,
                    e0: mkRes(0, 0, 25'h0, 1'b1, 32, 67), e1: mkRes(0, 0, 25'h0, 1'b1, 32, 67)};
        vecs[5] = '{len: 32, sm: 25'h40000,   lo: 31, hi: 31,
                    e0: mkRes(1, 31, 25'h40000, 1'b0, 32, 67), e1: mkRes(1, 31, 25'h40000, 1'b0, 32, 67)};
        vecs[6] = '{len: 1,  sm: 25'h2,       lo: 0,  hi: 0,
                    e0: mkRes(1, 0, 25'h2, 1'b0, 1, 5),   e1: mkRes(1, 0, 25'h2, 1'b0, 1, 5)};

        rst = 1'b1; cfgWe = 1'b0; cfgAddr = '0; cfgX = '0; cfgY = '0; cfgLen = '0; start = 1'b0;
        setSup(25'h0, 0, 0);
        #1 rst = 1'b0;
        repeat (3) @(negedge clk);
        for (int j = 0; j < 2; j++) begin
            checkVal("rst.dutRst", j, dutRst[j], 1);
            checkVal("rst.busy", j, busy[j], 0);
            checkVal("rst.done", j, done[j], 0);
            checkVal("rst.pass", j, pass[j], 0);
            checkVal("rst.dutAdv", j, dutAdv[j], 0);
            checkVal("rst.dutX", j, dutX[j], 0);
            checkVal("rst.cnt", j, mismatchCnt[j], 0);
            checkVal("rst.failMask", j, failMask[j], 0);
        end
        rst = 1'b1;
        loadTable(1'b0);

        $display("[TB] directed vectors");
        for (int v = 0; v < 7; v++) begin
            setSup(vecs[v].sm, vecs[v].lo, vecs[v].hi);
            applyStimulus(vecs[v].len, 0);
            checkOutput($sformatf("vec%0d", v), vecs[v].e0, vecs[v].e1);
        end

        $display("[TB] reset during CHECK");
        setSup(vecs[3].sm, vecs[3].lo, vecs[3].hi);
        @(negedge clk);
        cfgLen = 6'd8; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        n = 0;
        while (!dutAdv[0] && n < 20) begin
            @(negedge clk);
            n++;
        end
        checkVal("midRst.reachedCheck", 0, dutAdv[0], 1);
        rst = 1'b0;
        #1;
        for (int j = 0; j < 2; j++) begin
            checkVal("midRst.dutRst", j, dutRst[j], 1);
            checkVal("midRst.busy", j, busy[j], 0);
            checkVal("midRst.cnt", j, mismatchCnt[j], 0);
            checkVal("midRst.dutAdv", j, dutAdv[j], 0);
        end
        @(negedge clk);
        rst = 1'b1;
        applyStimulus(8, 0);
        checkOutput("afterRst", vecs[3].e0, vecs[3].e1);

        $display("[TB] table write while busy");
        applyStimulus(8, 3);
        checkOutput("busyWrite", vecs[3].e0, vecs[3].e1);
        applyStimulus(8, 0);
        checkOutput("busyWriteRerun", vecs[3].e0, vecs[3].e1);

        $display("[TB] randomized runs");
        loadTable(1'b1);
        for (int r = 0; r < 10; r++) begin
            sm  = ($urandom_range(0, 1) == 1) ? 25'($urandom) : 25'h0;
            lo  = $urandom_range(0, 31);
            setSup(sm, lo, $urandom_range(lo, 31));
            len = (r == 0) ? DEPTH : $urandom_range(0, DEPTH);
            applyStimulus(len, 0);
            checkOutput($sformatf("rand%0d", r),
                        refRun(len, 1'b1, supMask, supLo, supHi),
                        refRun(len, 1'b0, supMask, supLo, supHi));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
